rgmii_rx_decoder: RTL and testbench

RGMII_RX_DECODER -- requirements
Module: rgmii_rx_decoder

---
 rtl/rgmii_pkg.sv | 29 ++
 rtl/rgmii_rx_decoder_iddr.sv | 46 ++++
 rtl/rgmii_rx_decoder.sv | 155 +++++++++++++++
 tb/tb_rgmii_rx_decoder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII receive decoder.
package rgmii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } rx_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam logic [1:0] SPEED_10M  = 2'b00;
    localparam logic [1:0] SPEED_100M = 2'b01;
    localparam logic [1:0] SPEED_1G   = 2'b10;

    // One assembled receive symbol: byte plus its control qualifiers.
    typedef struct packed {
        logic [7:0] data;
        logic       dv;
        logic       er;
    } rx_byte_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rgmii_rx_decoder_iddr.sv
// Dual-edge input capture; the vendor branches only differ in the placement
// attributes that pull the capture flops into the I/O cells.
module iddr #(
    parameter string TARGET = "GENERIC",
    parameter int    WIDTH  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall
);

    if (TARGET == "XILINX") begin : g_xilinx
        (* IOB = "TRUE" *) logic [WIDTH-1:0] r_q, f_q;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) r_q <= '0;
            else        r_q <= d;
        always_ff @(negedge clk or negedge rst_n)
            if (!rst_n) f_q <= '0;
            else        f_q <= d;
        assign q_rise = r_q;
        assign q_fall = f_q;
    end else if (TARGET == "ALTERA") begin : g_altera
        (* useioff = 1 *) logic [WIDTH-1:0] r_q, f_q;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) r_q <= '0;
            else        r_q <= d;
        always_ff @(negedge clk or negedge rst_n)
            if (!rst_n) f_q <= '0;
            else        f_q <= d;
        assign q_rise = r_q;
        assign q_fall = f_q;
    end else begin : g_generic
        logic [WIDTH-1:0] r_q, f_q;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) r_q <= '0;
            else        r_q <= d;
        always_ff @(negedge clk or negedge rst_n)
            if (!rst_n) f_q <= '0;
            else        f_q <= d;
        assign q_rise = r_q;
        assign q_fall = f_q;
    end

endmodule

// File: rtl/rgmii_rx_decoder.sv
// RGMII receive path: DDR capture, preamble/SFD framing, one-byte hold-back
// for end-of-frame marking, in-band status and saturating frame counters.
module rgmii_rx_decoder
    import rgmii_pkg::*;
#(
    parameter string TARGET        = "GENERIC",
    parameter int    MAX_FRAME_LEN = 1522
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  rgmii_rxd,
    input  logic        rgmii_rx_ctl,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    output logic        m_error,
    output logic        link_up,
    output logic [1:0]  link_speed,
    output logic        full_duplex,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_err
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

    logic [4:0] cap_rise, cap_fall;
    rx_byte_t   rx;

    iddr #(.TARGET(TARGET), .WIDTH(5)) u_iddr (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      ({rgmii_rx_ctl, rgmii_rxd}),
        .q_rise (cap_rise),
        .q_fall (cap_fall)
    );

    // Rising-edge half still holds edge k here, so the pair is aligned.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rx <= '0;
        else begin
            rx.data <= {cap_fall[3:0], cap_rise[3:0]};
            rx.dv   <= cap_rise[4];
            rx.er   <= cap_rise[4] ^ cap_fall[4];
        end

    rx_state_e   state, state_nxt;
    logic [7:0]  held;
    logic        have_held, err_seen;
    logic [15:0] len;
    logic        start, take, emit, emit_last, emit_err, end_ok, end_err;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        take      = 1'b0;
        emit      = 1'b0;
        emit_last = 1'b0;
        emit_err  = 1'b0;
        end_ok    = 1'b0;
        end_err   = 1'b0;
        case (state)
            ST_IDLE:
                if (rx.dv) state_nxt = (rx.data == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
            ST_PREAMBLE:
                if (!rx.dv)                     state_nxt = ST_IDLE;
                else if (rx.er)                 state_nxt = ST_DROP;
                else if (rx.data == SFD_BYTE) begin
                    state_nxt = ST_DATA;
                    start     = 1'b1;
                end else if (rx.data != PREAMBLE_BYTE) state_nxt = ST_DROP;
            ST_DATA:
                if (rx.dv) begin
                    take = 1'b1;
                    emit = have_held;
                end else begin
                    state_nxt = ST_IDLE;
                    if (have_held) begin
                        emit      = 1'b1;
                        emit_last = 1'b1;
                        emit_err  = err_seen || (len > MAX_LEN);
                        end_ok    = !emit_err;
                        end_err   = emit_err;
                    end else begin
                        end_err   = 1'b1;   // SFD followed directly by end of frame
                    end
                end
            ST_DROP:
                if (!rx.dv) begin
                    state_nxt = ST_IDLE;
                    end_err   = 1'b1;
                end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            held       <= '0;
            have_held  <= 1'b0;
            err_seen   <= 1'b0;
            len        <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_error    <= 1'b0;
            frames_ok  <= '0;
            frames_err <= '0;
        end else begin
            if (start) begin
                have_held <= 1'b0;
                err_seen  <= 1'b0;
                len       <= '0;
            end
            if (take) begin
                held      <= rx.data;
                have_held <= 1'b1;
                len       <= sat_inc16(len);
                if (rx.er) err_seen <= 1'b1;
            end
            m_valid <= emit;
            m_last  <= emit_last;
            m_error <= emit_err;
            if (emit)    m_data     <= held;
            if (end_ok)  frames_ok  <= sat_inc16(frames_ok);
            if (end_err) frames_err <= sat_inc16(frames_err);
        end

    // Status needs two matching idle symbols in a row to reject glitches.
    logic       idle_sym, prev_idle;
    logic [3:0] prev_nib;

    assign idle_sym = !rx.dv && !rx.er;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            prev_idle   <= 1'b0;
            prev_nib    <= '0;
            link_up     <= 1'b0;
            link_speed  <= '0;
            full_duplex <= 1'b0;
        end else begin
            prev_idle <= idle_sym;
            prev_nib  <= rx.data[3:0];
            if (idle_sym && prev_idle && (prev_nib == rx.data[3:0])) begin
                link_up     <= rx.data[0];
                link_speed  <= rx.data[2:1];
                full_duplex <= rx.data[3];
            end
        end

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// Self-checking bench: directed frames, status vector table, random frames
// against a frame-level reference model, and mid-frame reset.
module tb_rgmii_rx_decoder;
    import rgmii_pkg::*;

    localparam int MAX_LEN = 1522;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rgmii_rxd = '0;
    logic        rgmii_rx_ctl = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid, m_last, m_error;
    logic        link_up, full_duplex;
    logic [1:0]  link_speed;
    logic [15:0] frames_ok, frames_err;

    rgmii_rx_decoder #(.TARGET("GENERIC"), .MAX_FRAME_LEN(MAX_LEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rgmii_rxd    (rgmii_rxd),
        .rgmii_rx_ctl (rgmii_rx_ctl),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_last       (m_last),
        .m_error      (m_error),
        .link_up      (link_up),
        .link_speed   (link_speed),
        .full_duplex  (full_duplex),
        .frames_ok    (frames_ok),
        .frames_err   (frames_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       err;
        int         cyc;
    } beat_t;

    typedef struct {
        logic [3:0] nib;
        logic       er;
        int         n;
        logic       exp_link;
        logic [1:0] exp_speed;
        logic       exp_dup;
    } st_vec_t;

    beat_t      got[$], exp_q[$];
    logic [7:0] fbs[$];
    logic       fers[$];
    int         edges[$];
    int         cyc = 0;
    int         checks = 0, errors = 0;
    int         exp_ok = 0, exp_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (m_valid) begin
            beat_t b;
            b.data = m_data; b.last = m_last; b.err = m_error; b.cyc = cyc;
            got.push_back(b);
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Low nibble + dv before the rising edge, high nibble + dv^er before the falling edge.
    task automatic send_byte(input logic [7:0] b, input logic dv, input logic er);
        rgmii_rxd = b[3:0]; rgmii_rx_ctl = dv;
        @(posedge clk); #1;
        edges.push_back(cyc);
        rgmii_rxd = b[7:4]; rgmii_rx_ctl = dv ^ er;
        @(negedge clk); #1;
    endtask

    task automatic send_frame();
        foreach (fbs[i]) send_byte(fbs[i], 1'b1, fers[i]);
        repeat (6) send_byte(8'h00, 1'b0, 1'b0);
    endtask

    task automatic mk_frame(input int pre, input int len, input int er_idx, input bit rnd);
        fbs.delete(); fers.delete();
        repeat (pre) begin fbs.push_back(8'h55); fers.push_back(1'b0); end
        fbs.push_back(8'hD5); fers.push_back(1'b0);
        for (int j = 0; j < len; j++) begin
            fbs.push_back(rnd ? 8'($urandom) : 8'(j + 1));
            fers.push_back(j == er_idx);
        end
    endtask

    // Frame-level expectation: strip 0x55 run, require 0xD5, everything after is payload.
    task automatic model_frame();
        int    i, n, nd;
        bit    bad;
        beat_t b;
        i = 0; n = fbs.size();
        if (n == 0) return;
        if (fbs[0] != 8'h55) begin exp_err++; return; end
        while (i < n && fbs[i] == 8'h55) i++;
        if (i == n) return;
        if (fbs[i] != 8'hD5) begin exp_err++; return; end
        nd = n - i - 1;
        if (nd == 0) begin exp_err++; return; end
        bad = (nd > MAX_LEN);
        for (int j = i + 1; j < n; j++) bad |= fers[j];
        for (int j = i + 1; j < n; j++) begin
            b.data = fbs[j]; b.last = (j == n - 1); b.err = (j == n - 1) && bad; b.cyc = 0;
            exp_q.push_back(b);
        end
        if (bad) exp_err++; else exp_ok++;
    endtask

    task automatic compare(input string name);
        chk({name, "_beats"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk({name, "_data"}, got[i].data, exp_q[i].data);
            chk({name, "_last"}, got[i].last, exp_q[i].last);
            chk({name, "_err"},  got[i].err,  exp_q[i].err);
        end
        chk({name, "_frames_ok"},  frames_ok,  exp_ok);
        chk({name, "_frames_err"}, frames_err, exp_err);
        got.delete(); exp_q.delete();
    endtask

    task automatic run_frame(input string name);
        edges.delete();
        send_frame();
        model_frame();
        compare(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    st_vec_t stv[7];

    initial begin
        int lasts, pre_rst;
        stv[0] = '{4'hD, 1'b0, 2, 1'b1, SPEED_1G,   1'b1};
        stv[1] = '{4'h3, 1'b0, 3, 1'b1, SPEED_100M, 1'b0};
        stv[2] = '{4'h6, 1'b0, 1, 1'b1, SPEED_100M, 1'b0};
        stv[3] = '{4'h6, 1'b1, 4, 1'b1, SPEED_100M, 1'b0};
        stv[4] = '{4'h4, 1'b0, 2, 1'b0, SPEED_1G,   1'b0};
        stv[5] = '{4'hB, 1'b0, 2, 1'b1, SPEED_100M, 1'b1};
        stv[6] = '{4'h0, 1'b0, 2, 1'b0, SPEED_10M,  1'b0};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_data", m_data, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_error", m_error, 0);
        chk("rst_link_up", link_up, 0);
        chk("rst_link_speed", link_speed, 0);
        chk("rst_full_duplex", full_duplex, 0);
        chk("rst_frames_ok", frames_ok, 0);
        chk("rst_frames_err", frames_err, 0);
        rst_n = 1'b1;
        repeat (3) send_byte(8'h00, 1'b0, 1'b0);

        // 64-byte good frame with latency check on non-last beats
        mk_frame(7, 64, -1, 1'b0);
        edges.delete();
        send_frame();
        model_frame();
        if (got.size() == 64) begin
            int late;
            late = 0;
            for (int j = 0; j < 63; j++) if (got[j].cyc - edges[8 + j] != 3) late++;
            chk("good_latency_first", got[0].cyc - edges[8], 3);
            chk("good_latency_bad_cnt", late, 0);
        end
        compare("good64");

        mk_frame(7, 64, 9, 1'b0);
        run_frame("er_byte10");

        fbs.delete(); fers.delete();
        fbs = '{8'h55, 8'h55, 8'hAA}; fers = '{1'b0, 1'b0, 1'b0};
        run_frame("bad_preamble");
        mk_frame(7, 16, -1, 1'b1);
        run_frame("after_bad");

        foreach (stv[i]) begin
            repeat (stv[i].n) send_byte({stv[i].nib, stv[i].nib}, 1'b0, stv[i].er);
            repeat (2) send_byte(8'h00, 1'b0, 1'b1);
            chk($sformatf("status%0d_link", i), link_up, stv[i].exp_link);
            chk($sformatf("status%0d_speed", i), link_speed, stv[i].exp_speed);
            chk($sformatf("status%0d_dup", i), full_duplex, stv[i].exp_dup);
        end

        repeat (4) send_byte(8'hDD, 1'b0, 1'b0);
        chk("glitch_pre_link", link_up, 1);
        send_byte(8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hDD, 1'b0, 1'b0);
            chk("glitch_link", link_up, 1);
            chk("glitch_speed", link_speed, SPEED_1G);
            chk("glitch_dup", full_duplex, 1);
        end

        mk_frame(7, MAX_LEN, -1, 1'b0);
        run_frame("len_max");
        mk_frame(7, MAX_LEN + 1, -1, 1'b0);
        run_frame("len_max_plus1");
        mk_frame(7, 0, -1, 1'b0);
        run_frame("zero_len");

        for (int f = 0; f < 40; f++) begin
            int kind, pre, len;
            logic [7:0] bb;
            kind = $urandom_range(0, 9);
            pre  = $urandom_range(1, 7);
            len  = $urandom_range(0, 80);
            if (kind == 0) begin
                mk_frame(pre, 0, -1, 1'b0);
                bb = 8'($urandom);
                if (bb == 8'h55 || bb == 8'hD5) bb = 8'h00;
                fbs[pre] = bb;
                repeat (len) begin fbs.push_back(8'($urandom)); fers.push_back(1'b0); end
            end else if (kind == 1) begin
                mk_frame(pre, 0, -1, 1'b0);
                void'(fbs.pop_back()); void'(fers.pop_back());
            end else begin
                mk_frame(pre, len, ($urandom_range(0, 5) == 0) ? $urandom_range(0, 80) : -1, 1'b1);
            end
            run_frame($sformatf("rand%0d", f));
        end

        // Reset in the middle of a payload, then the tail of the frame resumes
        mk_frame(7, 20, -1, 1'b0);
        foreach (fbs[i]) send_byte(fbs[i], 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_data", m_data, 0);
        chk("midrst_frames_ok", frames_ok, 0);
        chk("midrst_frames_err", frames_err, 0);
        pre_rst = got.size();
        send_byte(8'h15, 1'b1, 1'b0);
        send_byte(8'h16, 1'b1, 1'b0);
        rst_n = 1'b1;
        fbs.delete(); fers.delete();
        for (int j = 0; j < 20; j++) begin fbs.push_back(8'(8'h21 + j)); fers.push_back(1'b0); end
        send_frame();
        lasts = 0;
        foreach (got[i]) if (got[i].last) lasts++;
        chk("midrst_no_last", lasts, 0);
        chk("midrst_no_new_beats", got.size(), pre_rst);
        exp_ok = 0; exp_err = 0;
        model_frame();
        chk("midrst_frames_ok_after", frames_ok, exp_ok);
        chk("midrst_frames_err_after", frames_err, exp_err);
        chk("midrst_frames_err_one", frames_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
